// File: rtl/neuron_mac_ctrl_if.sv
// Stream and configuration bundle between a neuron sequencer and its neighbours.
// master drives weights/inputs and out_ready; slave is the neuron itself.
// Widths follow the Q3.12 sign-magnitude word (16 bits) and the weight index width AW.
interface neuron_mac_ctrl_if #(
  parameter int AW = 3
);
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [15:0]   cfg_wdata;
  logic          bias_we;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic          out_ovf;
  logic          busy;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, bias_we, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, bias_we, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );
endinterface

// File: rtl/neuron_mac_ctrl.sv
// Purpose: one neuron's bias + sum(x[i]*w[i]) in Q3.12 sign-magnitude, one shared mul and add stage.
// Latency: input handshake in cycle T accumulates in T+2; after the last input out_valid rises in T+3.
// Backpressure: result held stable in OUT until out_ready; in_ready=0 there. Saturation via NEURON_SAT_EN.
module neuron_mac_ctrl #(
  parameter int N_IN = 8,
  parameter int AW   = $clog2(N_IN)
) (
  input  logic           clk,
  input  logic           rst_n,
  neuron_mac_ctrl_if.slave bus
);

  typedef enum logic [1:0] {WAIT_IN, MUL, ADD, OUT} state_t;

  localparam logic [AW-1:0] LAST = AW'(N_IN - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic [15:0]   acc, x_r, prod_r, bias_r;
  logic [15:0]   w [N_IN];
  logic          ovf;
  logic          busy;
  logic          in_ready, out_valid;
  logic [16:0]   mres, ares;

  // Sign-magnitude multiply; result {ovf, word}. Zero operands short-circuit, 0x8000 is not zero.
  function automatic logic [16:0] mul_q(input logic [15:0] a, input logic [15:0] b);
    logic [29:0] p;
    logic [14:0] mag;
    logic        o;
    p   = 30'(a[14:0]) * 30'(b[14:0]);
    mag = p[26:12];
    o   = |p[29:27];
`ifdef NEURON_SAT_EN
    if (o) mag = 15'h7fff;
`endif
    if (a == 16'h0000 || b == 16'h0000) return 17'h0;
    return {o, a[15] ^ b[15], mag};
  endfunction

  // Sign-magnitude add; result {ovf, word}. Only same-sign sums can overflow.
  function automatic logic [16:0] add_q(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic [14:0] mag;
    logic        o;
    if (a[15] == b[15]) begin
      s   = {1'b0, a[14:0]} + {1'b0, b[14:0]};
      o   = s[15];
      mag = s[14:0];
`ifdef NEURON_SAT_EN
      if (o) mag = 15'h7fff;
`endif
      return {o, a[15], mag};
    end else if (a[14:0] == b[14:0]) begin
      return 17'h0;
    end else if (a[14:0] > b[14:0]) begin
      return {1'b0, a[15], a[14:0] - b[14:0]};
    end else begin
      return {1'b0, b[15], b[14:0] - a[14:0]};
    end
  endfunction

  assign busy = (state != WAIT_IN) || (idx != '0);
  assign mres = mul_q(x_r, w[idx]);
  assign ares = add_q((idx == '0) ? bias_r : acc, prod_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_IN;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      WAIT_IN: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = MUL;
      end
      MUL: state_nxt = ADD;
      ADD: state_nxt = (idx == LAST) ? OUT : WAIT_IN;
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = WAIT_IN;
      end
      default: state_nxt = WAIT_IN;
    endcase
  end

  // Datapath: input capture, product, accumulate, index and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      acc    <= '0;
      x_r    <= '0;
      prod_r <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        WAIT_IN: if (bus.in_valid) x_r <= bus.in_data;
        MUL: begin
          prod_r <= mres[15:0];
          if (mres[16]) ovf <= 1'b1;
        end
        ADD: begin
          acc <= ares[15:0];
          if (ares[16]) ovf <= 1'b1;
          idx <= (idx == LAST) ? '0 : idx + AW'(1);
        end
        OUT: if (bus.out_ready) ovf <= 1'b0;
        default: ;
      endcase
    end
  end

  // Weight and bias storage; writes are only honoured between vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_r <= '0;
      for (int i = 0; i < N_IN; i++) w[i] <= '0;
    end else if (!busy) begin
      if (bus.cfg_we)  w[bus.cfg_addr] <= bus.cfg_wdata;
      if (bus.bias_we) bias_r          <= bus.cfg_wdata;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = acc;
  assign bus.out_ovf   = ovf;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Directed + random bench for neuron_mac_ctrl with N_IN=4.
// Expected sums are queued when a vector is driven and popped when the result appears.
// Build with NEURON_SAT_EN defined to check the saturating variant.
module tb_neuron_mac_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_mac_ctrl_if #(.AW(2)) bus ();
  neuron_mac_ctrl #(.N_IN(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [15:0] data; logic ovf; } exp_t;
  typedef logic [15:0] vec_t [N];

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [15:0] wm [N];
  logic [15:0] bm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference arithmetic on signed integers, independent of bit slicing.
  function automatic logic [16:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    int mag;
    bit o;
    if (a == 16'h0 || b == 16'h0) return 17'h0;
    p   = longint'(a[14:0]) * longint'(b[14:0]);
    o   = (p >= 64'd134217728);
    mag = int'((p / 4096) % 32768);
`ifdef NEURON_SAT_EN
    if (o) mag = 32767;
`endif
    return {o, a[15] ^ b[15], 15'(mag)};
  endfunction

  function automatic logic [16:0] m_add(input logic [15:0] a, input logic [15:0] b);
    int va, vb, s, mag;
    bit o;
    va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
    vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
    s  = va + vb;
    if (a[15] == b[15]) begin
      mag = (s < 0) ? -s : s;
      o   = (mag > 32767);
      mag = mag % 32768;
`ifdef NEURON_SAT_EN
      if (o) mag = 32767;
`endif
      return {o, a[15], 15'(mag)};
    end
    if (s == 0) return 17'h0;
    return {1'b0, 1'(s < 0), 15'((s < 0) ? -s : s)};
  endfunction

  function automatic exp_t model_vec(input vec_t xs);
    exp_t e;
    logic [16:0] pr, ar;
    logic [15:0] acc;
    acc   = 16'h0;
    e.ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      pr    = m_mul(xs[i], wm[i]);
      ar    = m_add((i == 0) ? bm : acc, pr[15:0]);
      acc   = ar[15:0];
      e.ovf = e.ovf | pr[16] | ar[16];
    end
    e.data = acc;
    return e;
  endfunction

  task automatic push(input logic [15:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  // Config write; the model is updated only when the bench knows the block is idle.
  task automatic cfg(input bit we, input bit bwe, input logic [1:0] addr,
                     input logic [15:0] data, input bit idle);
    bus.cfg_we    = we;
    bus.bias_we   = bwe;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we  = 1'b0;
    bus.bias_we = 1'b0;
    if (idle) begin
      if (we)  wm[addr] = data;
      if (bwe) bm = data;
    end
  endtask

  task automatic send(input logic [15:0] x, input bit lat);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    for (int k = 0; k < 20 && !bus.in_ready; k++) tick();
    if (!bus.in_ready) chk("in_ready_wait", 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (lat) begin
      chk("lat_t1_out_valid", bus.out_valid, 0);
      tick();
      chk("lat_t2_out_valid", bus.out_valid, 0);
      tick();
      chk("lat_t3_out_valid", bus.out_valid, 1);
    end
  endtask

  task automatic run_vec(input vec_t xs, input bit lat);
    for (int i = 0; i < N; i++) send(xs[i], lat && (i == N - 1));
  endtask

  task automatic get_out(input int hold);
    exp_t e;
    for (int k = 0; k < 40 && !bus.out_valid; k++) tick();
    if (!bus.out_valid) begin
      chk("out_valid_wait", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("out_data", bus.out_data, e.data);
    chk("out_ovf", bus.out_ovf, e.ovf);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_out_data", bus.out_data, e.data);
      chk("hold_out_ovf", bus.out_ovf, e.ovf);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_busy", bus.busy, 1);
      chk("hold_out_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("post_hs_out_valid", bus.out_valid, 0);
    chk("post_hs_in_ready", bus.in_ready, 1);
    chk("post_hs_busy", bus.busy, 0);
  endtask

  initial begin
    vec_t v;
    bus.cfg_we    = 1'b0;
    bus.bias_we   = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) wm[i] = 16'h0;
    bm = 16'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_ovf", bus.out_ovf, 0);
    chk("rst_out_data", bus.out_data, 16'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", bus.in_ready, 1);

    // Basic sum: bias 0.5 + 1 + 2 - 1 + 0.5 = 3.0
    for (int i = 0; i < N; i++) cfg(1, 0, 2'(i), 16'h1000, 1);
    cfg(0, 1, 2'd0, 16'h0800, 1);
    v = '{16'h1000, 16'h2000, 16'h9000, 16'h0800};
    push(16'h3000, 1'b0);
    run_vec(v, 1);
    get_out(0);

    // Add overflow, with 5 cycles of backpressure
    for (int i = 0; i < N; i++) cfg(1, 0, 2'(i), 16'h7000, 1);
    cfg(0, 1, 2'd0, 16'h0000, 1);
    v = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
`ifdef NEURON_SAT_EN
    push(16'h7fff, 1'b1);
`else
    push(16'h4000, 1'b1);
`endif
    run_vec(v, 0);
    get_out(5);

    // Product overflow: 4.0 * 4.0
    cfg(1, 0, 2'd0, 16'h4000, 1);
    v = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
`ifdef NEURON_SAT_EN
    push(16'h7fff, 1'b1);
`else
    push(16'h0000, 1'b1);
`endif
    run_vec(v, 0);
    get_out(0);

    // Cancellation: 1.5 + (-1.5) = 0, ovf cleared from previous vector
    cfg(1, 0, 2'd0, 16'h1000, 1);
    cfg(1, 0, 2'd1, 16'h1000, 1);
    v = '{16'h1800, 16'h9800, 16'h0000, 16'h0000};
    push(16'h0000, 1'b0);
    run_vec(v, 0);
    get_out(0);

    // Config lockout: write to w[0] mid-vector is dropped
    v = '{16'h1000, 16'h1000, 16'h0000, 16'h0000};
    push(16'h2000, 1'b0);
    send(v[0], 0);
    chk("midvec_busy", bus.busy, 1);
    cfg(1, 0, 2'd0, 16'h2000, 0);
    for (int i = 1; i < N; i++) send(v[i], 0);
    get_out(0);
    v = '{16'h1000, 16'h0000, 16'h0000, 16'h0000};
    push(16'h1000, 1'b0);
    run_vec(v, 0);
    get_out(0);
    cfg(1, 0, 2'd0, 16'h2000, 1);
    push(16'h2000, 1'b0);
    run_vec(v, 0);
    get_out(0);

    // Simultaneous weight and bias write share the data word
    cfg(1, 1, 2'd1, 16'h0800, 1);
    v = '{16'h0000, 16'h1000, 16'h0000, 16'h0000};
    push(16'h1000, 1'b0);
    run_vec(v, 0);
    get_out(0);

    // Random vectors against the reference model
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) cfg(1, 0, 2'(i), 16'($urandom_range(0, 16'hffff)), 1);
      cfg(0, 1, 2'd0, 16'($urandom_range(0, 16'hffff)), 1);
      for (int i = 0; i < N; i++) v[i] = 16'($urandom_range(0, 16'hffff));
      sb.push_back(model_vec(v));
      run_vec(v, 0);
      get_out(r);
    end

    // Reset mid-vector aborts and clears weights and bias
    cfg(1, 1, 2'd0, 16'h1000, 1);
    send(16'h1000, 0);
    send(16'h1000, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midrst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < N; i++) wm[i] = 16'h0;
    bm = 16'h0;
    v = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    push(16'h0000, 1'b0);
    run_vec(v, 0);
    get_out(0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
